// File: rtl/smc_pkg.sv
// Shared types and constants for the smc_serial front-end.
// The idle timeout default is only consumed when SMC_TIMEOUT_EN is defined.
package smc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      AVG  = 2'd2,
      OUT  = 2'd3
   } smc_state_t;

   localparam int NUM_FET            = 6;
   localparam int VAL_W              = 7;
   localparam int OUT_W              = 8;
   localparam int CNT_W              = 3;
   localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/smc_fet_eval.sv
// Combinational per-transistor evaluation: Id or gm, then divided by three.
module smc_fet_eval
   import smc_pkg::*;
(
   input  logic [2:0]       W,
   input  logic [2:0]       V_GS,
   input  logic [2:0]       V_DS,
   input  logic             mode_id,
   output logic [VAL_W-1:0] val
);

   logic [2:0] vgs1;
   logic       triode;
   logic [7:0] w8, vds8, vgs8, raw;

   assign vgs1   = V_GS - 3'd1;
   assign triode = (vgs1 > V_DS);

   // The true raw value always fits in 8 bits, so modular 8-bit products are exact.
   always_comb begin
      w8   = {5'b0, W};
      vds8 = {5'b0, V_DS};
      vgs8 = {5'b0, vgs1};
      raw  = '0;
      if (mode_id) begin
         if (triode) raw = w8 * vds8 * ((vgs8 << 1) - vds8);
         else        raw = w8 * vgs8 * vgs8;
      end else begin
         if (triode) raw = (w8 * vds8) << 1;
         else        raw = (w8 * vgs8) << 1;
      end
      val = VAL_W'(raw / 8'd3);
   end

endmodule

// File: rtl/smc_serial.sv
// Serial MOSFET calculator front-end: six beats per job, sorted buffer, top/bottom-three average.
// Optional feature macro SMC_TIMEOUT_EN adds an idle timeout while loading a job.
module smc_serial
   import smc_pkg::*;
`ifdef SMC_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [2:0]       W,
   input  logic [2:0]       V_GS,
   input  logic [2:0]       V_DS,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_n
);

   smc_state_t       state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [1:0]       mode_reg, mode_next;
   logic [VAL_W-1:0] buf_reg  [NUM_FET];
   logic [VAL_W-1:0] buf_next [NUM_FET];
   logic [VAL_W-1:0] ins_buf  [NUM_FET];
   logic             out_valid_reg, out_valid_next;
   logic [OUT_W-1:0] out_n_reg, out_n_next;

`ifdef SMC_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0] idle_reg, idle_next;
`endif

   logic             eval_mode_id;
   logic [VAL_W-1:0] new_val;
   logic [CNT_W-1:0] valid_cnt;
   logic [NUM_FET-1:0] keep;

   // The first beat of a job evaluates with the live mode before it is latched.
   assign eval_mode_id = (state_reg == IDLE) ? mode[0] : mode_reg[0];
   assign valid_cnt    = (state_reg == IDLE) ? '0 : count_reg;
   assign in_ready     = (state_reg == IDLE) || (state_reg == LOAD);
   assign out_valid    = out_valid_reg;
   assign out_n        = out_n_reg;

   smc_fet_eval u_eval (
      .W       (W),
      .V_GS    (V_GS),
      .V_DS    (V_DS),
      .mode_id (eval_mode_id),
      .val     (new_val)
   );

   // Valid entries >= the new value stay put, so equal values keep arrival order.
   for (genvar gi = 0; gi < NUM_FET; gi++) begin : g_ins
      assign keep[gi] = (CNT_W'(gi) < valid_cnt) && (buf_reg[gi] >= new_val);
      if (gi == 0) begin : g_head
         assign ins_buf[gi] = keep[gi] ? buf_reg[gi] : new_val;
      end else begin : g_tail
         assign ins_buf[gi] = keep[gi]     ? buf_reg[gi]   :
                              keep[gi-1]   ? new_val       : buf_reg[gi-1];
      end
   end

   logic [VAL_W-1:0] sel_a, sel_b, sel_c;
   logic [9:0]       a10, b10, c10, wsum, psum, avg10;

   always_comb begin
      sel_a = mode_reg[1] ? buf_reg[0] : buf_reg[3];
      sel_b = mode_reg[1] ? buf_reg[1] : buf_reg[4];
      sel_c = mode_reg[1] ? buf_reg[2] : buf_reg[5];
      a10   = 10'(sel_a);
      b10   = 10'(sel_b);
      c10   = 10'(sel_c);
      wsum  = 10'd3 * a10 + 10'd4 * b10 + 10'd5 * c10;
      psum  = a10 + b10 + c10;
      avg10 = mode_reg[0] ? (wsum / 10'd12) : (psum / 10'd3);
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      mode_next      = mode_reg;
      buf_next       = buf_reg;
      out_valid_next = 1'b0;
      out_n_next     = '0;
`ifdef SMC_TIMEOUT_EN
      idle_next      = idle_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               mode_next  = mode;
               buf_next   = ins_buf;
               count_next = CNT_W'(1);
               state_next = LOAD;
`ifdef SMC_TIMEOUT_EN
               idle_next  = '0;
`endif
            end
         end
         LOAD: begin
            if (in_valid) begin
               buf_next   = ins_buf;
               count_next = count_reg + CNT_W'(1);
               if (count_reg == CNT_W'(NUM_FET - 1)) state_next = AVG;
`ifdef SMC_TIMEOUT_EN
               idle_next  = '0;
            end else if (idle_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
               state_next = IDLE;
               count_next = '0;
               idle_next  = '0;
            end else begin
               idle_next  = idle_reg + IDLE_W'(1);
`endif
            end
         end
         AVG: begin
            out_valid_next = 1'b1;
            out_n_next     = OUT_W'(avg10);
            state_next     = OUT;
         end
         OUT: begin
            count_next = '0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         mode_reg      <= '0;
         out_valid_reg <= 1'b0;
         out_n_reg     <= '0;
         for (int i = 0; i < NUM_FET; i++) buf_reg[i] <= '0;
`ifdef SMC_TIMEOUT_EN
         idle_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         mode_reg      <= mode_next;
         out_valid_reg <= out_valid_next;
         out_n_reg     <= out_n_next;
         buf_reg       <= buf_next;
`ifdef SMC_TIMEOUT_EN
         idle_reg      <= idle_next;
`endif
      end
   end

endmodule

// File: tb/tb_smc_serial.sv
// Self-checking bench for smc_serial: directed jobs, reset abort, random jobs vs a sort-and-average model.
// Exercises the SMC_TIMEOUT_EN idle timeout when that macro is defined.
module tb_smc_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [2:0] W = 3'd0, V_GS = 3'd1, V_DS = 3'd0;
   logic       in_ready, out_valid;
   logic [7:0] out_n;

   int passed = 0;
   int total  = 0;

   logic [2:0] jw [6];
   logic [2:0] jg [6];
   logic [2:0] jd [6];
   logic [1:0] jm;

   smc_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .W         (W),
      .V_GS      (V_GS),
      .V_DS      (V_DS),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_n     (out_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int fet_val(input int w, input int g, input int d, input bit id);
      int v, raw;
      v = g - 1;
      if (v > d) raw = id ? w * d * (2 * v - d) : 2 * w * d;
      else       raw = id ? w * v * v           : 2 * w * v;
      return raw / 3;
   endfunction

   function automatic int expect_job();
      int vals[$];
      int a, b, c;
      for (int i = 0; i < 6; i++) vals.push_back(fet_val(jw[i], jg[i], jd[i], jm[0]));
      vals.rsort();
      if (jm[1]) begin a = vals[0]; b = vals[1]; c = vals[2]; end
      else       begin a = vals[3]; b = vals[4]; c = vals[5]; end
      return jm[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
   endfunction

   task automatic drive_beat(input int i);
      in_valid = 1'b1;
      W    = jw[i];
      V_GS = jg[i];
      V_DS = jd[i];
      mode = (i == 0) ? jm : 2'($urandom_range(3));
      @(posedge clk); #1;
   endtask

   task automatic send_job(input string tag, input int gap_max, input bit hold, input int exp);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(gap_max)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         drive_beat(i);
      end
      in_valid = hold;
      W = 3'($urandom_range(7)); V_GS = 3'd7; V_DS = 3'($urandom_range(7));
      check({tag, "_ready_avg"}, in_ready, 0);
      check({tag, "_valid_avg"}, out_valid, 0);
      @(posedge clk); #1;
      check({tag, "_valid_out"}, out_valid, 1);
      check({tag, "_out_n"}, out_n, exp);
      check({tag, "_ready_out"}, in_ready, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_valid_after"}, out_valid, 0);
      check({tag, "_n_after"}, out_n, 0);
      check({tag, "_ready_after"}, in_ready, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", in_ready, 1);
      check("reset_valid", out_valid, 0);
      check("reset_out_n", out_n, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      jm = 2'b11;
      for (int i = 0; i < 6; i++) begin jw[i] = 3'd7; jg[i] = 3'd7; jd[i] = 3'd7; end
      send_job("all84", 0, 1'b0, 84);

      jm = 2'b00;
      for (int i = 0; i < 6; i++) begin jw[i] = 3'(i + 1); jg[i] = 3'd2; jd[i] = 3'd1; end
      send_job("gm_bottom", 0, 1'b0, 1);

      jm = 2'b10;
      send_job("gm_top", 0, 1'b1, 3);

      jm = 2'b01;
      for (int i = 0; i < 6; i++) begin jw[i] = 3'(i + 1); jg[i] = 3'd5; jd[i] = 3'd1; end
      send_job("id_wbottom", 2, 1'b0, 3);

      jm = 2'b11;
      for (int i = 0; i < 6; i++) begin jw[i] = 3'd7; jg[i] = 3'd7; jd[i] = 3'd7; end
      for (int i = 0; i < 3; i++) drive_beat(i);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_valid", out_valid, 0);
      check("abort_ready", in_ready, 1);
      send_job("after_abort", 0, 1'b0, 84);

`ifdef SMC_TIMEOUT_EN
      for (int i = 0; i < 3; i++) drive_beat(i);
      in_valid = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         check("timeout_no_valid", out_valid, 0);
      end
      check("timeout_ready", in_ready, 1);
      jm = 2'b00;
      for (int i = 0; i < 6; i++) begin jw[i] = 3'(i + 1); jg[i] = 3'd2; jd[i] = 3'd1; end
      send_job("after_timeout", 0, 1'b0, 1);
`endif

      for (int j = 0; j < 24; j++) begin
         jm = 2'($urandom_range(3));
         for (int i = 0; i < 6; i++) begin
            jw[i] = 3'($urandom_range(7));
            jg[i] = 3'($urandom_range(7, 1));
            jd[i] = 3'($urandom_range(7));
         end
         send_job($sformatf("rand%0d", j), 4, 1'($urandom_range(1)), expect_job());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/smc_serial.md
# smc_serial

Sequential front-end for the Supper MOSFET Calculator. It accepts one transistor (W, V_GS, V_DS) per handshake beat, six beats per job, and evaluates Id or gm per beat. Each result is insertion-sorted into a 6-entry buffer; the block then reports the plain or weighted average of the top or bottom three. It sits on the producer side of the SMC datapath and replaces the six-wide parallel input bus with a narrow serial stream.

## Interface
- TIMEOUT_CYCLES, 15, maximum idle cycles between beats inside a job (used only with SMC_TIMEOUT_EN)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat strobe; accepted only when in_ready=1
- mode  input  2  sampled on first beat of a job only; bit0: 1=Id, 0=gm; bit1: 1=top three, 0=bottom three
- W, V_GS, V_DS  input  3 each  transistor parameters; legal V_GS range 1..7
- in_ready  output  1  high in IDLE and LOAD
- out_valid  output  1  one-cycle result pulse
- out_n  output  8  result; 0 whenever out_valid=0

## Operation
- States: IDLE -> LOAD -> AVG -> OUT -> IDLE.
- IDLE: first accepted beat latches mode, inserts entry 0, sets beat count to 1, moves to LOAD.
- LOAD: each accepted beat inserts one entry. The 6th beat moves to AVG.
- Per-beat evaluation (vgs1 = V_GS-1, 3 bits):
  - Triode when vgs1 > V_DS, else saturation.
  - Id triode = W*V_DS*(2*vgs1-V_DS); Id saturation = W*vgs1*vgs1.
  - gm triode = 2*W*V_DS; gm saturation = 2*W*vgs1.
  - Raw value is 8 bits. Stored value = floor(raw/3), 7 bits, max 84.
- Insertion: buffer is kept descending (s0 largest). A new value shifts down every entry strictly smaller than it, so equal values keep arrival order. Buffer contents are not cleared between jobs; the count gates validity.
- AVG: selects a,b,c = s0,s1,s2 (mode[1]=1) or s3,s4,s5 (mode[1]=0), with a>=b>=c.
  - mode[0]=1: result = floor((3a+4b+5c)/12).
  - mode[0]=0: result = floor((a+b+c)/3).
  - Intermediates are 10 bits; result is zero-extended to 8 bits and registered.
- OUT: out_valid=1 with out_n=result for exactly one cycle, then IDLE.
- in_valid is ignored while in_ready=0, i.e. in AVG and OUT. No beat is lost or buffered.
- Reset values: state IDLE, count 0, out_valid 0, out_n 0, in_ready 1.
- Reset asserted mid-job (any state) aborts the job. No out_valid is produced for it, and the next job starts clean.

## Timing
- The beat accepted at edge t is inserted at edge t.
- Last (6th) beat at edge t: AVG during cycle t+1, out_valid high in cycle t+2.
- in_ready drops in the cycle after the 6th beat. It returns high in the cycle after out_valid.
- Minimum job period: 8 cycles (6 beats plus 2).
- Gaps (in_valid=0) inside LOAD are legal and only stall the job.

## Configuration
- SMC_TIMEOUT_EN defined:
  - An idle counter in LOAD counts consecutive cycles with in_valid=0 and clears on every accepted beat.
  - Reaching TIMEOUT_CYCLES returns the block to IDLE with count 0 and no out_valid.
- SMC_TIMEOUT_EN undefined: no counter; LOAD waits indefinitely.

## Structure
- Package smc_pkg holds:
  - the state enum (IDLE, LOAD, AVG, OUT);
  - NUM_FET=6, VAL_W=7, OUT_W=8;
  - the default TIMEOUT_CYCLES.
- One combinational sub-module, smc_fet_eval: inputs W, V_GS, V_DS and mode bit0; output is the 7-bit divided value.
- Top level holds the FSM, beat counter, sort buffer, averaging and output registers.

## Test plan
- mode=11, six beats W=7,V_GS=7,V_DS=7 (all 84) -> out_n=84, out_valid exactly 2 cycles after the 6th beat.
- mode=00, W=1..6 with V_GS=2,V_DS=1 (values 0,1,2,2,3,4) -> bottom three 2,1,0 -> out_n=1.
- mode=10, same beats as the previous case -> top three 4,3,2 -> out_n=3.
- mode=01, W=1..6 with V_GS=5,V_DS=1 (triode; 2,4,7,9,11,14) -> bottom three 7,4,2 -> floor(47/12) -> out_n=3.
- Three beats, then rst for one cycle, then the first case's six beats -> no out_valid for the aborted job, then out_n=84.
- Random gaps in in_valid plus in_valid held high during AVG/OUT:
  - results match the reference model and the extra beats are ignored;
  - with SMC_TIMEOUT_EN, a gap of 15 idle cycles after beat 3 returns to IDLE with no output;
  - the next six beats form a fresh job.
